stopwatch_lap_ctrl: RTL and testbench
=====================================

Name: stopwatch_lap_ctrl

Overview:
Sequencing controller for the stopwatch datapath. Turns single-cycle button pulses into the datapath's run/clear controls through a Moore FSM. Adds lap capture: a frozen display while counting continues, plus a LAP_DEPTH-entry lap buffer that can be recalled while stopped. Sits between the button debouncers and the stopwatch datapath/FND display mux, and is gated by sw_mode (stopwatch active when sw_mode=0).

Parameters:
BIT_100HZ, 100, msec modulus; width WM = $clog2(BIT_100HZ)
SECOND_60, 60, sec/min modulus; width WS = $clog2(SECOND_60)
HOUR, 24, hour modulus; width WH = $clog2(HOUR)
LAP_DEPTH, 4, lap buffer entries (power of 2, >=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sw_mode  in  1  1 = watch mode; all buttons ignored, o_run/o_clear forced 0
btn_run  in  1  one-cycle pulse, run/stop toggle
btn_clear  in  1  one-cycle pulse, clear
btn_lap  in  1  one-cycle pulse, lap / recall
i_msec, i_sec, i_min, i_hour  in  WM/WS/WS/WH  live datapath time
o_run  out  1  datapath run enable
o_clear  out  1  datapath clear (one-cycle pulse)
disp_msec, disp_sec, disp_min, disp_hour  out  WM/WS/WS/WH  time to display
lap_freeze  out  1  display holding a captured lap while running
lap_count  out  $clog2(LAP_DEPTH+1)  valid laps stored, saturating
recall_idx  out  $clog2(LAP_DEPTH)  lap entry shown in recall
recall_active  out  1  display showing a stored lap

Behaviour:
- Reset (sync): state=STOP. o_run=0, o_clear=0, lap_freeze=0, lap_count=0, recall_idx=0, recall_active=0, hold regs=0, write pointer=0. disp_* = live inputs.
- FSM states: STOP, RUN, CLEAR. Outputs decoded from registered state: o_run=(RUN)&!sw_mode; o_clear=(CLEAR)&!sw_mode.
- Transitions when sw_mode=0:
  - STOP + btn_run -> RUN
  - RUN + btn_run -> STOP
  - STOP + btn_clear -> CLEAR
  - CLEAR -> STOP unconditionally. o_clear is high exactly 1 cycle.
  - btn_clear in RUN is ignored.
- sw_mode=1: state, lap buffer and freeze are held and all button pulses are dropped. On return to 0, the state resumes.
- Button priority per cycle: run > clear > lap. Only the highest-priority pulse is acted on; the others are dropped.
- Lap in RUN, lap_freeze=0:
  - Capture i_* into the hold regs and into the lap buffer at the write pointer. Both occur on the same edge the pulse is sampled.
  - Set lap_freeze=1 next cycle.
  - Increment the write pointer mod LAP_DEPTH; the oldest entry is overwritten when full.
  - Increment lap_count, saturating at LAP_DEPTH.
- Lap in RUN, lap_freeze=1: lap_freeze<=0. Nothing is stored.
- RUN->STOP clears lap_freeze.
- Lap in STOP:
  - lap_count=0: ignored.
  - recall_active=0: recall_active<=1 and recall_idx<=newest entry, i.e. (wptr-1) mod LAP_DEPTH.
  - recall_active=1: step recall_idx to the next-older entry. After the oldest valid entry, recall_active<=0.
- STOP->RUN clears recall_active.
- CLEAR: lap_count<=0, write pointer<=0, recall_active<=0, lap_freeze<=0. Buffer contents need not be zeroed.
- Display mux priority: recall_active -> lap_buf[recall_idx]; else lap_freeze -> hold regs; else live i_*. This mux is combinational, so live values pass through with 0 latency.
- All values are passed through unmodified; there is no arithmetic on time fields.

Decomposition:
- Shared package stopwatch_pkg: state enum {STOP, RUN, CLEAR}; width constants WM/WS/WH; packed time struct {hour, min, sec, msec}.
- One natural sub-module: lap_buffer. It holds the LAP_DEPTH x time-struct register file, write pointer and count, and exposes wr_en, clr, rd_idx, rd_data, count, newest_idx.

Test Plan:
- Reset, then btn_run pulse -> o_run=1 from the next cycle. Second btn_run -> o_run=0. btn_clear -> o_clear=1 for exactly 1 cycle, state returns to STOP.
- RUN with live time 0:00:05.37, btn_lap -> disp shows 0:00:05.37 while i_* advances, lap_freeze=1, lap_count=1. Second btn_lap -> disp follows live time again.
- 5 laps with LAP_DEPTH=4 (times t1..t5), then stop -> lap_count=4. Recall presses show t5, t4, t3, t2, then recall_active=0.
- btn_run and btn_clear in the same cycle while in STOP -> RUN entered, no o_clear. btn_clear while in RUN -> no effect.
- sw_mode=1 while in RUN -> o_run=0 and button pulses ignored. sw_mode back to 0 -> o_run=1 again with lap state intact.
- Reset asserted mid-RUN while frozen with 3 laps stored -> next cycle: STOP, lap_count=0, lap_freeze=0, disp = live inputs.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and field widths for the stopwatch controller.
package stopwatch_pkg;

    localparam int unsigned BIT_100HZ = 100;
    localparam int unsigned SECOND_60 = 60;
    localparam int unsigned HOUR      = 24;

    localparam int unsigned WM = $clog2(BIT_100HZ);
    localparam int unsigned WS = $clog2(SECOND_60);
    localparam int unsigned WH = $clog2(HOUR);

    typedef enum logic [1:0] {
        StStop,
        StRun,
        StClear
    } sw_state_e;

    typedef struct packed {
        logic [WH-1:0] hour;
        logic [WS-1:0] min;
        logic [WS-1:0] sec;
        logic [WM-1:0] msec;
    } sw_time_t;

endpackage

// File: rtl/stopwatch_lap_ctrl_if.sv
// Button, live-time and display signals between the stopwatch controller and its neighbours.
interface stopwatch_lap_ctrl_if #(
    parameter int unsigned LAP_DEPTH = 4
) ();
    import stopwatch_pkg::*;

    localparam int unsigned CW = $clog2(LAP_DEPTH + 1);
    localparam int unsigned IW = $clog2(LAP_DEPTH);

    logic          sw_mode;
    logic          btn_run;
    logic          btn_clear;
    logic          btn_lap;
    logic [WM-1:0] i_msec;
    logic [WS-1:0] i_sec;
    logic [WS-1:0] i_min;
    logic [WH-1:0] i_hour;
    logic          o_run;
    logic          o_clear;
    logic [WM-1:0] disp_msec;
    logic [WS-1:0] disp_sec;
    logic [WS-1:0] disp_min;
    logic [WH-1:0] disp_hour;
    logic          lap_freeze;
    logic [CW-1:0] lap_count;
    logic [IW-1:0] recall_idx;
    logic          recall_active;

    modport master (
        output sw_mode, btn_run, btn_clear, btn_lap, i_msec, i_sec, i_min, i_hour,
        input  o_run, o_clear, disp_msec, disp_sec, disp_min, disp_hour,
        input  lap_freeze, lap_count, recall_idx, recall_active
    );

    modport slave (
        input  sw_mode, btn_run, btn_clear, btn_lap, i_msec, i_sec, i_min, i_hour,
        output o_run, o_clear, disp_msec, disp_sec, disp_min, disp_hour,
        output lap_freeze, lap_count, recall_idx, recall_active
    );

endinterface

// File: rtl/stopwatch_lap_ctrl_lap_buffer.sv
// Circular lap register file; the oldest entry is overwritten once full, count saturates.
module stopwatch_lap_ctrl_lap_buffer
    import stopwatch_pkg::*;
#(
    parameter int unsigned LAP_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic                           clr,
    input  sw_time_t                       wr_data,
    input  logic [$clog2(LAP_DEPTH)-1:0]   rd_idx,
    output sw_time_t                       rd_data,
    output logic [$clog2(LAP_DEPTH+1)-1:0] count,
    output logic [$clog2(LAP_DEPTH)-1:0]   newest_idx
);

    localparam int unsigned CW = $clog2(LAP_DEPTH + 1);
    localparam int unsigned IW = $clog2(LAP_DEPTH);

    sw_time_t      mem_q [LAP_DEPTH];
    logic [IW-1:0] wptr_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            wptr_q  <= '0;
            count_q <= '0;
        end else if (wr_en) begin
            wptr_q <= wptr_q + IW'(1);
            if (count_q != CW'(LAP_DEPTH)) begin
                count_q <= count_q + CW'(1);
            end
        end
    end

    assign rd_data    = mem_q[rd_idx];
    assign count      = count_q;
    assign newest_idx = wptr_q - IW'(1);

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Run/stop/clear sequencing FSM with lap freeze, lap buffer and recall for the stopwatch.
module stopwatch_lap_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned LAP_DEPTH = 4
) (
    input logic                 clk,
    input logic                 reset,
    stopwatch_lap_ctrl_if.slave bus
);

    localparam int unsigned CW = $clog2(LAP_DEPTH + 1);
    localparam int unsigned IW = $clog2(LAP_DEPTH);

    sw_state_e     state_q, state_d;
    logic          act_run, act_clear, act_lap;
    logic          lap_wr, lap_clr;
    logic [CW-1:0] lap_count;
    logic [IW-1:0] newest_idx, oldest_idx;
    sw_time_t      live, rd_data, disp;
    sw_time_t      hold_q, hold_d;
    logic          freeze_q, freeze_d;
    logic          recall_q, recall_d;
    logic [IW-1:0] recall_idx_q, recall_idx_d;

    // Only the highest-priority pulse survives; everything is dropped in watch mode.
    always_comb begin
        act_run   = !bus.sw_mode && bus.btn_run;
        act_clear = !bus.sw_mode && !bus.btn_run && bus.btn_clear;
        act_lap   = !bus.sw_mode && !bus.btn_run && !bus.btn_clear && bus.btn_lap;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StStop;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!bus.sw_mode) begin
            unique case (state_q)
                StStop:  if (act_run) state_d = StRun; else if (act_clear) state_d = StClear;
                StRun:   if (act_run) state_d = StStop;
                StClear: state_d = StStop;
                default: state_d = StStop;
            endcase
        end
    end

    always_comb begin
        bus.o_run   = (state_q == StRun) && !bus.sw_mode;
        bus.o_clear = (state_q == StClear) && !bus.sw_mode;
    end

    assign live    = {bus.i_hour, bus.i_min, bus.i_sec, bus.i_msec};
    assign lap_wr  = (state_q == StRun) && act_lap && !freeze_q;
    assign lap_clr = (state_q == StStop) && act_clear;
    assign oldest_idx = newest_idx - IW'(lap_count - CW'(1));

    stopwatch_lap_ctrl_lap_buffer #(
        .LAP_DEPTH(LAP_DEPTH)
    ) u_lap_buffer (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (lap_wr),
        .clr        (lap_clr),
        .wr_data    (live),
        .rd_idx     (recall_idx_q),
        .rd_data    (rd_data),
        .count      (lap_count),
        .newest_idx (newest_idx)
    );

    always_comb begin
        hold_d       = hold_q;
        freeze_d     = freeze_q;
        recall_d     = recall_q;
        recall_idx_d = recall_idx_q;
        if (lap_clr) begin
            freeze_d = 1'b0;
            recall_d = 1'b0;
        end
        if (state_q == StRun) begin
            if (act_run) begin
                freeze_d = 1'b0;
            end else if (act_lap) begin
                freeze_d = !freeze_q;
                if (!freeze_q) hold_d = live;
            end
        end
        if (state_q == StStop) begin
            if (act_run) begin
                recall_d = 1'b0;
            end else if (act_lap && lap_count != '0) begin
                // Walk newest -> oldest, then drop back to the live display.
                if (!recall_q) begin
                    recall_d     = 1'b1;
                    recall_idx_d = newest_idx;
                end else if (recall_idx_q == oldest_idx) begin
                    recall_d = 1'b0;
                end else begin
                    recall_idx_d = recall_idx_q - IW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q       <= '0;
            freeze_q     <= 1'b0;
            recall_q     <= 1'b0;
            recall_idx_q <= '0;
        end else begin
            hold_q       <= hold_d;
            freeze_q     <= freeze_d;
            recall_q     <= recall_d;
            recall_idx_q <= recall_idx_d;
        end
    end

    always_comb begin
        if (recall_q) begin
            disp = rd_data;
        end else if (freeze_q) begin
            disp = hold_q;
        end else begin
            disp = live;
        end
    end

    assign bus.disp_hour     = disp.hour;
    assign bus.disp_min      = disp.min;
    assign bus.disp_sec      = disp.sec;
    assign bus.disp_msec     = disp.msec;
    assign bus.lap_freeze    = freeze_q;
    assign bus.lap_count     = lap_count;
    assign bus.recall_idx    = recall_idx_q;
    assign bus.recall_active = recall_q;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Directed plus randomized bench for stopwatch_lap_ctrl against a queue-based behavioural model.
module tb_stopwatch_lap_ctrl;
    import stopwatch_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stopwatch_lap_ctrl_if #(.LAP_DEPTH(DEPTH)) bus ();

    stopwatch_lap_ctrl #(
        .LAP_DEPTH(DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int ntests = 0;
    int nfail  = 0;

    // Behavioural model: laps kept oldest-first, recall position counted back from newest.
    bit       m_running, m_clearing, m_freeze, m_recall;
    int       m_pos, m_wr;
    logic [1:0] m_idx;
    sw_time_t m_hold, live_t;
    sw_time_t laps [$];

    function automatic sw_time_t mk_time(int h, int m, int s, int ms);
        sw_time_t t;
        t.hour = WH'(h);
        t.min  = WS'(m);
        t.sec  = WS'(s);
        t.msec = WM'(ms);
        return t;
    endfunction

    function automatic sw_time_t rand_time();
        return mk_time(int'($urandom_range(HOUR - 1)), int'($urandom_range(SECOND_60 - 1)),
                       int'($urandom_range(SECOND_60 - 1)), int'($urandom_range(BIT_100HZ - 1)));
    endfunction

    task automatic model_reset();
        m_running = 0; m_clearing = 0; m_freeze = 0; m_recall = 0;
        m_pos = 0; m_wr = 0; m_idx = 2'd0; m_hold = '0;
        laps.delete();
    endtask

    task automatic model_edge();
        bit r, c, l;
        if (reset) begin
            model_reset();
            return;
        end
        if (bus.sw_mode) return;
        r = bus.btn_run;
        c = bus.btn_clear && !r;
        l = bus.btn_lap && !r && !bus.btn_clear;
        if (m_clearing) begin
            m_clearing = 0;
        end else if (m_running) begin
            if (r) begin
                m_running = 0;
                m_freeze  = 0;
            end else if (l) begin
                if (!m_freeze) begin
                    laps.push_back(live_t);
                    if (laps.size() > DEPTH) void'(laps.pop_front());
                    m_wr++;
                    m_hold = live_t;
                end
                m_freeze = !m_freeze;
            end
        end else begin
            if (r) begin
                m_running = 1;
                m_recall  = 0;
            end else if (c) begin
                m_clearing = 1;
                laps.delete();
                m_wr = 0; m_recall = 0; m_freeze = 0;
            end else if (l && laps.size() != 0) begin
                if (!m_recall) begin
                    m_recall = 1;
                    m_pos    = 0;
                    m_idx    = 2'(m_wr - 1);
                end else if (m_pos == laps.size() - 1) begin
                    m_recall = 0;
                end else begin
                    m_pos++;
                    m_idx = 2'(m_wr - 1 - m_pos);
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        sw_time_t e;
        if (m_recall) e = laps[laps.size() - 1 - m_pos];
        else if (m_freeze) e = m_hold;
        else e = live_t;
        chk({tag, "/o_run"}, 32'(bus.o_run), 32'(m_running && !bus.sw_mode));
        chk({tag, "/o_clear"}, 32'(bus.o_clear), 32'(m_clearing && !bus.sw_mode));
        chk({tag, "/freeze"}, 32'(bus.lap_freeze), 32'(m_freeze));
        chk({tag, "/count"}, 32'(bus.lap_count), 32'(laps.size()));
        chk({tag, "/recall"}, 32'(bus.recall_active), 32'(m_recall));
        chk({tag, "/ridx"}, 32'(bus.recall_idx), 32'(m_idx));
        chk({tag, "/disp"}, 32'({bus.disp_hour, bus.disp_min, bus.disp_sec, bus.disp_msec}),
            32'(e));
    endtask

    task automatic cycle_t(input string tag, input bit r, input bit c, input bit l,
                           input sw_time_t t);
        bus.btn_run   = r;
        bus.btn_clear = c;
        bus.btn_lap   = l;
        bus.i_hour    = t.hour;
        bus.i_min     = t.min;
        bus.i_sec     = t.sec;
        bus.i_msec    = t.msec;
        live_t        = t;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
        bus.btn_run   = 1'b0;
        bus.btn_clear = 1'b0;
        bus.btn_lap   = 1'b0;
    endtask

    task automatic cycle(input string tag, input bit r, input bit c, input bit l);
        cycle_t(tag, r, c, l, rand_time());
    endtask

    initial begin
        model_reset();
        reset       = 1'b1;
        bus.sw_mode = 1'b0;
        cycle("reset", 0, 0, 0);
        cycle("reset", 0, 0, 0);
        reset = 1'b0;

        // Run / stop / clear basics
        cycle("run_on", 1, 0, 0);
        cycle("running", 0, 0, 0);
        cycle("run_off", 1, 0, 0);
        cycle("clear", 0, 1, 0);
        cycle("clear_done", 0, 0, 0);

        // Single lap at 0:00:05.37 while the live time keeps moving
        cycle("run2", 1, 0, 0);
        cycle_t("lap_cap", 0, 0, 1, mk_time(0, 0, 5, 37));
        repeat (3) cycle("lap_hold", 0, 0, 0);
        cycle("lap_release", 0, 0, 1);
        cycle("live_again", 0, 0, 0);

        // Five laps into a four-deep buffer, then recall newest to oldest
        cycle("stop", 1, 0, 0);
        cycle("clr2", 0, 1, 0);
        cycle("idle", 0, 0, 0);
        cycle("run3", 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle("lapN_cap", 0, 0, 1);
            cycle("lapN_rel", 0, 0, 1);
            cycle("lapN_gap", 0, 0, 0);
        end
        cycle("stop5", 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle("recall", 0, 0, 1);
            cycle("recall_gap", 0, 0, 0);
        end

        // Priority and ignored clear in RUN
        cycle("run_clr_same", 1, 1, 0);
        cycle("clr_in_run", 0, 1, 0);
        cycle("clr_lap_in_run", 0, 1, 1);

        // Watch mode while running and frozen
        cycle("lap_sw", 0, 0, 1);
        bus.sw_mode = 1'b1;
        cycle("sw_run", 1, 0, 0);
        cycle("sw_clr", 0, 1, 0);
        cycle("sw_lap", 0, 0, 1);
        bus.sw_mode = 1'b0;
        cycle("sw_back", 0, 0, 0);

        // Reset mid-run, frozen, three laps stored
        cycle("stop6", 1, 0, 0);
        cycle("clr6", 0, 1, 0);
        cycle("idle6", 0, 0, 0);
        cycle("run6", 1, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cycle("lap6_cap", 0, 0, 1);
            cycle("lap6_rel", 0, 0, 1);
        end
        cycle("lap6_frozen", 0, 0, 1);
        reset = 1'b1;
        cycle("reset_mid", 0, 0, 0);
        reset = 1'b0;
        cycle("after_reset", 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            reset       = ($urandom_range(199) == 0);
            bus.sw_mode = ($urandom_range(11) == 0);
            cycle("rand", $urandom_range(5) == 0, $urandom_range(7) == 0,
                  $urandom_range(2) == 0);
        end
        reset       = 1'b0;
        bus.sw_mode = 1'b0;

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
